// File: rtl/fb_pkg.sv
// Shared constants and FSM state encoding for the framebuffer pixel writer.
package fb_pkg;

   localparam int X_W    = 10;
   localparam int Y_W    = 9;
   localparam int ADDR_W = 19;

   localparam logic [X_W-1:0] H_RES = 10'd640;
   localparam logic [Y_W-1:0] V_RES = 9'd480;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } fb_state_t;

   // y*640 + x without a multiplier: 640 = 512 + 128
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
      logic [ADDR_W-1:0] yw;
      yw = ADDR_W'(y);
      return (yw << 9) + (yw << 7) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous FIFO buffering pixels between the raster stage and the write stage.
module fb_pixel_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips raster pixels, buffers them and streams linear framebuffer writes.
// Optional FB_PIXEL_DEDUP_EN drops a pixel identical to the last one enqueued.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int COLOR_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic [X_W-1:0]     pix_x,
   input  logic [Y_W-1:0]     pix_y,
   input  logic [COLOR_W-1:0] pix_color,
   output logic               pix_ready,
   input  logic               flush_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_data,
   input  logic               mem_ready,
   output logic               done,
   output logic [19:0]        wr_count,
   output logic [15:0]        drop_count
);

   localparam int ENTRY_W = X_W + Y_W + COLOR_W;

   fb_state_t            state;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic [ENTRY_W-1:0]   fifo_rd;
   logic                 accept;
   logic                 in_range;
   logic                 is_dup;
   logic                 write_done;
   logic                 flush_clear;
   logic [X_W-1:0]       head_x;
   logic [Y_W-1:0]       head_y;
   logic [COLOR_W-1:0]   head_color;

   assign pix_ready   = reset && (state == ST_RUN) && !fifo_full;
   assign accept      = pix_valid && pix_ready;
   assign in_range    = (pix_x < H_RES) && (pix_y < V_RES);
   assign write_done  = mem_we && mem_ready;
   assign fifo_push   = accept && in_range && !is_dup;
   assign fifo_pop    = !fifo_empty && (!mem_we || mem_ready);
   assign flush_clear = fifo_empty && (!mem_we || mem_ready);
   assign {head_x, head_y, head_color} = fifo_rd;

   fb_pixel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .wr_data ({pix_x, pix_y, pix_color}),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef FB_PIXEL_DEDUP_EN
   logic               last_valid;
   logic [ENTRY_W-1:0] last_pix;

   assign is_dup = last_valid && (last_pix == {pix_x, pix_y, pix_color});

   always_ff @(posedge clk) begin
      if (!reset || state == ST_DONE) begin
         last_valid <= 1'b0;
         last_pix   <= '0;
      end else if (fifo_push) begin
         last_valid <= 1'b1;
         last_pix   <= {pix_x, pix_y, pix_color};
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   // Flush ends the cycle the last write completes, so done follows it directly
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_RUN;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (flush_req) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (flush_clear) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else if (fifo_pop) begin
         mem_we   <= 1'b1;
         mem_addr <= pix_addr(head_x, head_y);
         mem_data <= head_color;
      end else if (mem_ready) begin
         mem_we   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_count   <= '0;
         drop_count <= '0;
      end else begin
         if (write_done) wr_count <= wr_count + 20'd1;
         if (accept && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

endmodule
